// File: rtl/reg_bank_w_if.sv
// rtl/reg_bank_w_if.sv - write/read bus bundle for the reg_bank_w register bank
interface reg_bank_w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] Write_data;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  // Datapath side: drives write and read indices, receives read data.
  modport master (
    output RegWrite, WriteReg, Write_data, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2
  );

  // Register bank side.
  modport slave (
    input  RegWrite, WriteReg, Write_data, ReadReg1, ReadReg2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/reg_bank_w.sv
// rtl/reg_bank_w.sv - 32x32 MIPS register bank, $zero hard-wired, $sp reset base; optional REGBANK_BYPASS_EN write-first forwarding
module reg_bank_w #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 227
) (
  input  logic          clk,
  input  logic          reset_n,
  reg_bank_w_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              wr_en;

  // r0 is never stored to; the read mux forces it to zero anyway.
  assign wr_en = bus.RegWrite && (bus.WriteReg != '0);

  // Storage: asynchronous reset to zero (SP to its stack base), then indexed write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (wr_en) begin
      regs[bus.WriteReg] <= bus.Write_data;
    end
  end

  // Combinational read ports; forwarding only exists in the bypass build.
  always_comb begin
    rd1 = (bus.ReadReg1 == '0) ? '0 : regs[bus.ReadReg1];
    rd2 = (bus.ReadReg2 == '0) ? '0 : regs[bus.ReadReg2];
`ifdef REGBANK_BYPASS_EN
    if (reset_n && wr_en && (bus.ReadReg1 == bus.WriteReg)) rd1 = bus.Write_data;
    if (reset_n && wr_en && (bus.ReadReg2 == bus.WriteReg)) rd2 = bus.Write_data;
`endif
  end

  assign bus.ReadData1 = rd1;
  assign bus.ReadData2 = rd2;
endmodule

// File: tb/tb_reg_bank_w.sv
// tb/tb_reg_bank_w.sv - self-checking bench for reg_bank_w (vector table, corner sequences, random vs. model)
`timescale 1ns/1ps
module tb_reg_bank_w;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] mem [32];

  reg_bank_w_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_bank_w dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[29] = 32'd227;
  endtask

  // Architectural view of a read given the currently driven bus inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (BYP && reset_n && bus.RegWrite && bus.WriteReg == idx) return bus.Write_data;
    return mem[idx];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.RegWrite   = we;
    bus.WriteReg   = wr;
    bus.Write_data = wd;
    bus.ReadReg1   = r1;
    bus.ReadReg2   = r2;
  endtask

  // One clock edge; model takes the write the bank should take.
  task automatic tick();
    @(posedge clk);
    if (reset_n && bus.RegWrite && bus.WriteReg != 5'd0) mem[bus.WriteReg] = bus.Write_data;
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd29, BYP ? 32'hDEADBEEF : 32'h0, 32'd227};
    vecs[1] = '{1'b0, 5'd8,  32'h00000001, 5'd8,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  32'h0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd0,  32'h0, 32'h0};
    vecs[4] = '{1'b1, 5'd12, 32'h00000011, 5'd8,  5'd12, 32'hDEADBEEF, BYP ? 32'h11 : 32'h0};
    vecs[5] = '{1'b1, 5'd12, 32'h00000022, 5'd12, 5'd5,  BYP ? 32'h22 : 32'h11, 32'h0};
    vecs[6] = '{1'b1, 5'd29, 32'h00000100, 5'd12, 5'd29, 32'h22, BYP ? 32'h100 : 32'd227};
    vecs[7] = '{1'b0, 5'd29, 32'h00000000, 5'd29, 5'd8,  32'h100, 32'hDEADBEEF};

    drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd5);
    model_reset();

    // Asynchronous reset pulse entirely between clock edges.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_sp_rd1", bus.ReadData1, 32'd227);
    chk("rst_r5_rd2", bus.ReadData2, 32'h0);
    bus.ReadReg1 = 5'd0;
    #0.5;
    chk("rst_r0_rd1", bus.ReadData1, 32'h0);
    #0.5 reset_n = 1'b1;
    tick();

    // Directed vectors: expectations are pre-edge reads of that cycle.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("vec%0d_rd1", i), bus.ReadData1, vecs[i].e1);
      chk($sformatf("vec%0d_rd2", i), bus.ReadData2, vecs[i].e2);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
    #1;
    chk("post_edge_r12", bus.ReadData1, 32'h22);

    // Reset asserted while a write to SP is pending across a clock edge.
    drive(1'b1, 5'd29, 32'h55, 5'd29, 5'd12);
    #1 reset_n = 1'b0;
    #1;
    chk("sprst_during", bus.ReadData1, 32'd227);
    @(posedge clk);
    #1;
    chk("sprst_edge", bus.ReadData1, 32'd227);
    reset_n = 1'b1;
    bus.RegWrite = 1'b0;
    #1;
    chk("sprst_after", bus.ReadData1, 32'd227);
    chk("sprst_r12", bus.ReadData2, 32'h0);
    model_reset();
    tick();

    // Unknown write index with writes disabled must not disturb anything.
    bus.RegWrite = 1'b0;
    bus.WriteReg = 'x;
    bus.Write_data = 32'hBAD0BAD0;
    tick();
    bus.WriteReg = 5'd0;

    // Sweep: fill r1..r31, then read mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
      tick();
    end
    bus.RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.ReadReg1 = 5'(i);
      bus.ReadReg2 = 5'(31 - i);
      #1;
      chk($sformatf("sweep_rd1_r%0d", i), bus.ReadData1, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
      chk($sformatf("sweep_rd2_r%0d", 31 - i), bus.ReadData2,
          (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101);
    end
    for (int i = 1; i < 32; i++) mem[i] = 32'(i) * 32'h01010101;

    // Random traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, 5'($urandom % 32), $urandom,
            5'($urandom % 32), 5'($urandom % 32));
      if (($urandom % 5) == 0) bus.ReadReg1 = bus.WriteReg;
      #1;
      chk("rand_rd1", bus.ReadData1, exp_read(bus.ReadReg1));
      chk("rand_rd2", bus.ReadData2, exp_read(bus.ReadReg2));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
